// File: rtl/sik_fetch.sv
// Fetch/decode front end: issues pc to instruction memory, folds Pre prefixes
// into a 16-bit immediate and hands one decoded record at a time to execute.
//
//   state   | meaning
//   ISSUE   | pc on imem_addr, memory read in flight
//   CAPTURE | imem_rdata valid; fold a Pre or build a record
//   HOLD    | record presented, waiting for dec_ready
//   HALT    | frozen after halt_in, left only by reset
module sik_fetch (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_in,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [3:0]  dec_op,
  output logic [11:0] dec_arg,
  output logic [15:0] dec_imm,
  output logic        dec_pre,
  output logic [15:0] dec_pc,
  output logic        halted
);

  typedef enum logic [1:0] {ISSUE, CAPTURE, HOLD, HALT} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [3:0]  pre_reg;
  logic        pre_ld;
  logic        is_pre;
  logic [15:0] sext_imm;

  assign imem_addr = pc;
  assign is_pre    = (imem_rdata[15:12] == 4'd7);
  assign sext_imm  = {{4{imem_rdata[11]}}, imem_rdata[11:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ISSUE;
      pc        <= 16'h0000;
      pre_reg   <= 4'h0;
      pre_ld    <= 1'b0;
      dec_valid <= 1'b0;
      dec_op    <= 4'h0;
      dec_arg   <= 12'h000;
      dec_imm   <= 16'h0000;
      dec_pre   <= 1'b0;
      dec_pc    <= 16'h0000;
      halted    <= 1'b0;
    end else if (halt_in) begin
      state     <= HALT;
      dec_valid <= 1'b0;
      halted    <= 1'b1;
    end else if (redirect && state != HALT) begin
      // Any in-flight word or pending prefix belongs to the old path.
      state     <= ISSUE;
      pc        <= redirect_pc;
      pre_ld    <= 1'b0;
      dec_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          pc <= pc + 16'd1;
          if (is_pre) begin
            pre_reg <= imem_rdata[3:0];
            pre_ld  <= 1'b1;
            state   <= ISSUE;
          end else begin
            dec_op    <= imem_rdata[15:12];
            dec_arg   <= imem_rdata[11:0];
            dec_imm   <= pre_ld ? {pre_reg, imem_rdata[11:0]} : sext_imm;
            dec_pre   <= pre_ld;
            dec_pc    <= pc;
            pre_ld    <= 1'b0;
            dec_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (dec_ready) begin
            dec_valid <= 1'b0;
            state     <= ISSUE;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
